mcycle_mdu: RTL and testbench

Parametrised iterative multiply/divide unit that executes the full RISC-V M-extension op set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits beside the ALU in the execute stage and talks to the core over valid/ready handshakes on input and output. Latency scales with WIDTH/RADIX_BITS. It adds a pipeline flush input and a single-cycle path for the divide-by-zero and signed-overflow special cases.

---
 rtl/mdu_pkg.sv | 46 ++++
 rtl/mdu_radix_step.sv | 44 ++++
 rtl/mcycle_mdu.sv | 215 +++++++++++++++++++++
 tb/tb_mcycle_mdu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RISC-V M-extension multiply/divide unit.
package mdu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_MUL    = 3'b000;
    localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'b011;
    localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'b101;
    localparam logic [OP_W-1:0] OP_REM    = 3'b110;
    localparam logic [OP_W-1:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int unsigned steps(input int unsigned width, input int unsigned radix_bits);
        return width / radix_bits;
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    // MUL is handled as signed x signed; its low word is identical for every signedness.
    function automatic logic is_signed_a(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // High word: MULH/MULHSU/MULHU product or REM/REMU remainder.
    function automatic logic result_hi(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
               (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mdu_radix_step.sv
// One RADIX_BITS-wide iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module mdu_radix_step #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RADIX_BITS = 8
) (
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     opnd,
    input  logic [2*WIDTH-1:0]   acc,
    output logic [2*WIDTH-1:0]   acc_next_c
);

    localparam int unsigned MW = WIDTH + RADIX_BITS;

    logic [MW-1:0]      mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     r;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    // Multiply: acc = {partial_hi, unconsumed multiplier}; add mcand*digit then shift right.
    always_comb begin
        mul_sum  = MW'(acc[2*WIDTH-1:WIDTH]) + MW'(opnd) * MW'(acc[RADIX_BITS-1:0]);
        mul_next = (2*WIDTH)'({mul_sum, acc[WIDTH-1:0]} >> RADIX_BITS);
    end

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    always_comb begin
        rem = acc[2*WIDTH-1:WIDTH];
        quo = acc[WIDTH-1:0];
        r   = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            r   = {rem, quo[WIDTH-1]};
            quo = {quo[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, opnd}) begin
                r      = r - {1'b0, opnd};
                quo[0] = 1'b1;
            end
            rem = r[WIDTH-1:0];
        end
    end

    assign acc_next_c = is_div ? {rem, quo} : mul_next;

endmodule

// File: rtl/mcycle_mdu.sv
// Iterative multiply/divide unit for the full RISC-V M op set with valid/ready handshakes.
// Optional result reuse of the last completed computation is enabled by defining MDU_REUSE_EN.
module mcycle_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RADIX_BITS = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned STEPS = steps(WIDTH, RADIX_BITS);
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_n;
    logic [OP_W-1:0]    op_q, op_n;
    logic [WIDTH-1:0]   opnd_q, opnd_n;
    logic [2*WIDTH-1:0] acc_q, acc_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               a_neg_q, a_neg_n;
    logic               b_neg_q, b_neg_n;
    logic [WIDTH-1:0]   result_q, result_n;
    logic               out_valid_q, out_valid_n;
    logic               busy_q, busy_n;
    logic               in_ready_q, in_ready_n;

    logic               accept_c;
    logic               sa_c, sb_c, a_neg_c, b_neg_c;
    logic [WIDTH-1:0]   a_mag_c, b_mag_c;
    logic               div_zero_c, ovf_c, special_c;
    logic [WIDTH-1:0]   special_res_c;
    logic               div_q_c;
    logic [2*WIDTH-1:0] step_c;
    logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;
    logic [2*WIDTH-1:0] fixed_c;
    logic               reuse_hit_c;
    logic [WIDTH-1:0]   reuse_res_c;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

    assign accept_c = in_valid & in_ready_q & ~flush;

    // Operand sign/magnitude split at accept.
    assign sa_c    = is_signed_a(op);
    assign sb_c    = is_signed_b(op);
    assign a_neg_c = sa_c & operand_a[WIDTH-1];
    assign b_neg_c = sb_c & operand_b[WIDTH-1];
    assign a_mag_c = a_neg_c ? -operand_a : operand_a;
    assign b_mag_c = b_neg_c ? -operand_b : operand_b;

    // Divide-by-zero and signed overflow resolve in one edge.
    assign div_zero_c    = (operand_b == '0);
    assign ovf_c         = ~op[0] & (operand_a == MIN_VAL) & (operand_b == {WIDTH{1'b1}});
    assign special_c     = is_div(op) & (div_zero_c | ovf_c);
    assign special_res_c = div_zero_c ? (op[1] ? operand_a : {WIDTH{1'b1}})
                                      : (op[1] ? {WIDTH{1'b0}} : MIN_VAL);

    assign div_q_c = is_div(op_q);

    mdu_radix_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .is_div     (div_q_c),
        .opnd       (opnd_q),
        .acc        (acc_q),
        .acc_next_c (step_c)
    );

    // Sign fix-up: quotient/product take a^b, remainder takes a.
    assign quo_fix_c = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix_c = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign fixed_c   = div_q_c ? {rem_fix_c, quo_fix_c}
                               : ((a_neg_q ^ b_neg_q) ? -acc_q : acc_q);

`ifdef MDU_REUSE_EN
    logic [WIDTH-1:0] reuse_a_q, reuse_b_q;
    logic             reuse_sa_q, reuse_sb_q, reuse_div_q, reuse_vld_q;

    // acc_q holds the signed-fixed 2*WIDTH result after FIX until the next computation starts.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            reuse_a_q   <= '0;
            reuse_b_q   <= '0;
            reuse_sa_q  <= 1'b0;
            reuse_sb_q  <= 1'b0;
            reuse_div_q <= 1'b0;
            reuse_vld_q <= 1'b0;
        end else if (flush || (accept_c && special_c)) begin
            reuse_vld_q <= 1'b0;
        end else if (accept_c && !reuse_hit_c) begin
            reuse_a_q   <= operand_a;
            reuse_b_q   <= operand_b;
            reuse_sa_q  <= sa_c;
            reuse_sb_q  <= sb_c;
            reuse_div_q <= is_div(op);
            reuse_vld_q <= 1'b0;
        end else if (state_q == S_FIX) begin
            reuse_vld_q <= 1'b1;
        end
    end

    assign reuse_hit_c = reuse_vld_q && (operand_a == reuse_a_q) && (operand_b == reuse_b_q) &&
                         (is_div(op) == reuse_div_q) &&
                         ((op == OP_MUL) || ((sa_c == reuse_sa_q) && (sb_c == reuse_sb_q)));
    assign reuse_res_c = result_hi(op) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
`else
    assign reuse_hit_c = 1'b0;
    assign reuse_res_c = '0;
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_n;
            op_q        <= op_n;
            opnd_q      <= opnd_n;
            acc_q       <= acc_n;
            cnt_q       <= cnt_n;
            a_neg_q     <= a_neg_n;
            b_neg_q     <= b_neg_n;
            result_q    <= result_n;
            out_valid_q <= out_valid_n;
            busy_q      <= busy_n;
            in_ready_q  <= in_ready_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        op_n     = op_q;
        opnd_n   = opnd_q;
        acc_n    = acc_q;
        cnt_n    = cnt_q;
        a_neg_n  = a_neg_q;
        b_neg_n  = b_neg_q;
        result_n = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    op_n    = op;
                    a_neg_n = a_neg_c;
                    b_neg_n = b_neg_c;
                    if (special_c) begin
                        result_n = special_res_c;
                        state_n  = S_DONE;
                    end else if (reuse_hit_c) begin
                        result_n = reuse_res_c;
                        state_n  = S_DONE;
                    end else begin
                        opnd_n  = is_div(op) ? b_mag_c : a_mag_c;
                        acc_n   = {{WIDTH{1'b0}}, (is_div(op) ? a_mag_c : b_mag_c)};
                        cnt_n   = '0;
                        state_n = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_n = step_c;
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_n = S_FIX;
                end
            end
            S_FIX: begin
                acc_n    = fixed_c;
                result_n = result_hi(op_q) ? fixed_c[2*WIDTH-1:WIDTH] : fixed_c[WIDTH-1:0];
                state_n  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Flush wins over everything, including a pending out_ready handshake.
        if (flush) begin
            state_n = S_IDLE;
        end

        out_valid_n = (state_n == S_DONE);
        busy_n      = (state_n != S_IDLE);
        in_ready_n  = (state_n == S_IDLE);
    end

endmodule

// File: tb/tb_mcycle_mdu.sv
// Directed self-checking bench for mcycle_mdu (WIDTH=32, RADIX_BITS=8); honours MDU_REUSE_EN.
module tb_mcycle_mdu;
    import mdu_pkg::*;

`ifdef MDU_REUSE_EN
    localparam int REUSE_LAT = 1;
`else
    localparam int REUSE_LAT = 6;
`endif

    logic        CLK;
    logic        RESETn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mcycle_mdu #(.WIDTH(32), .RADIX_BITS(8)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op (called #1 after a rising edge with the unit idle), return result and
    // latency in edges counting the accept edge as 1, then consume the result.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy_all);
        op = o; operand_a = a; operand_b = b; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0; op = ~o; operand_a = ~a; operand_b = ~b;
        lat = 1;
        busy_all = busy;
        while (!out_valid && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            busy_all &= busy;
        end
        res = result;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge CLK); RESETn = 1'b1;
        @(posedge CLK); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_mul();
        logic [31:0] res; int lat; logic bz;
        do_op(OP_MUL, 32'd7, 32'hFFFFFFFD, res, lat, bz);
        n_checks++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_res: got %h expected ffffffeb", res); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL mul_lat: got %0d expected 6", lat); end
        n_checks++; if (bz !== 1'b1) begin n_fail++; $display("FAIL mul_busy: got %b expected 1", bz); end
        do_op(OP_MULH, 32'h80000000, 32'h80000000, res, lat, bz);
        n_checks++; if (res !== 32'h40000000) begin n_fail++; $display("FAIL mulh_res: got %h expected 40000000", res); end
        do_op(OP_MULHSU, 32'hFFFFFFFF, 32'd2, res, lat, bz);
        n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu_res: got %h expected ffffffff", res); end
        do_op(OP_MULHU, 32'hFFFFFFFF, 32'd2, res, lat, bz);
        n_checks++; if (res !== 32'h00000001) begin n_fail++; $display("FAIL mulhu_res: got %h expected 00000001", res); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL mulhu_lat: got %0d expected 6", lat); end
    endtask

    task automatic test_div();
        logic [31:0] res; int lat; logic bz;
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, res, lat, bz);
        n_checks++; if (res !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_res: got %h expected fffffffd", res); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL div_lat: got %0d expected 6", lat); end
        do_op(OP_REM, 32'hFFFFFFF9, 32'd2, res, lat, bz);
        n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem_res: got %h expected ffffffff", res); end
        n_checks++; if (lat !== REUSE_LAT) begin n_fail++; $display("FAIL rem_lat: got %0d expected %0d", lat, REUSE_LAT); end
        do_op(OP_DIVU, 32'd100, 32'd7, res, lat, bz);
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_res: got %h expected 0000000e", res); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL divu_lat: got %0d expected 6", lat); end
        do_op(OP_REMU, 32'd100, 32'd7, res, lat, bz);
        n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu_res: got %h expected 00000002", res); end
    endtask

    task automatic test_special();
        logic [31:0] res; int lat; logic bz;
        do_op(OP_DIVU, 32'h1234, 32'h0, res, lat, bz);
        n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_res: got %h expected ffffffff", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divu0_lat: got %0d expected 1", lat); end
        do_op(OP_REMU, 32'h1234, 32'h0, res, lat, bz);
        n_checks++; if (res !== 32'h1234) begin n_fail++; $display("FAIL remu0_res: got %h expected 00001234", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL remu0_lat: got %0d expected 1", lat); end
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, res, lat, bz);
        n_checks++; if (res !== 32'h80000000) begin n_fail++; $display("FAIL divovf_res: got %h expected 80000000", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divovf_lat: got %0d expected 1", lat); end
        do_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, res, lat, bz);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL removf_res: got %h expected 00000000", res); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL removf_lat: got %0d expected 1", lat); end
    endtask

    task automatic test_backpressure();
        int w = 0;
        op = OP_MUL; operand_a = 32'd3; operand_b = 32'd5; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        while (!out_valid && w < 20) begin @(posedge CLK); #1; w++; end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_done_timeout: out_valid %b after %0d cycles", out_valid, w); end
        for (int i = 0; i < 3; i++) begin
            op = OP_MUL; operand_a = 32'd1; operand_b = 32'd1; in_valid = 1'b1;
            @(posedge CLK); #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
            n_checks++; if (result !== 32'd15) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %h expected 0000000f", i, result); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_flush();
        logic [31:0] res; int lat; logic bz; logic seen;
        op = OP_MUL; operand_a = 32'd2; operand_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy: got %b expected 0", busy); end
        op = OP_MUL; operand_a = 32'd9; operand_b = 32'd9; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_calc_busy: got %b expected 1", busy); end
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        seen = 1'b0;
        repeat (8) begin @(posedge CLK); #1; seen |= out_valid; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_result: out_valid seen %b expected 0", seen); end
        do_op(OP_MUL, 32'd6, 32'd7, res, lat, bz);
        n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL post_flush_res: got %h expected 0000002a", res); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL post_flush_lat: got %0d expected 6", lat); end
    endtask

    task automatic test_reuse();
        logic [31:0] res; int lat; logic bz;
        do_op(OP_DIV, 32'd100, 32'd7, res, lat, bz);
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL reuse_div_res: got %h expected 0000000e", res); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL reuse_div_lat: got %0d expected 6", lat); end
        do_op(OP_REM, 32'd100, 32'd7, res, lat, bz);
        n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL reuse_rem_res: got %h expected 00000002", res); end
        n_checks++; if (lat !== REUSE_LAT) begin n_fail++; $display("FAIL reuse_rem_lat: got %0d expected %0d", lat, REUSE_LAT); end
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        do_op(OP_REM, 32'd100, 32'd7, res, lat, bz);
        n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL reuse_flushed_res: got %h expected 00000002", res); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL reuse_flushed_lat: got %0d expected 6", lat); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res; int lat; logic bz;
        op = OP_MUL; operand_a = 32'd7; operand_b = 32'd7; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        #2 RESETn = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b expected 0", busy); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL areset_result: got %h expected 0", result); end
        @(negedge CLK); RESETn = 1'b1;
        @(posedge CLK); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_idle_valid: got %b expected 0", out_valid); end
        do_op(OP_MUL, 32'd7, 32'd7, res, lat, bz);
        n_checks++; if (res !== 32'd49) begin n_fail++; $display("FAIL areset_mul_res: got %h expected 00000031", res); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL areset_mul_lat: got %0d expected 6", lat); end
    endtask

    initial begin
        RESETn    = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        operand_a = 32'h0;
        operand_b = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reuse();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
